// File: rtl/mpp_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : mpp_pattern_player
// Purpose  : Plays the BEACON / DIGITAL_LF sample patterns with burst count,
//            per-period gain, graceful stop and a done pulse. Optional macro
//            MPP_PATTERN_SAT_EN makes the output reduction saturate.
// Revision : 1.0 - initial release
// ============================================================================
module mpp_pattern_player #(
    parameter int ROM_W      = 24,
    parameter int OUT_W      = 24,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 7,
    parameter int BURST_W    = 8,
    parameter int BEACON_LEN = 40,
    parameter int DIGLF_LEN  = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic                    stop,
    input  logic [BURST_W-1:0]      burst_len,
    input  logic [GAIN_W-1:0]       gain,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int c_MAX_LEN = (BEACON_LEN > DIGLF_LEN) ? BEACON_LEN : DIGLF_LEN;
    localparam int c_IDX_W   = $clog2(c_MAX_LEN);
    localparam int c_PROD_W  = ROM_W + GAIN_W + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PLAY  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]                r_state;
    logic                      r_beacon;
    logic [c_IDX_W-1:0]        r_idx;
    logic [BURST_W-1:0]        r_burst;
    logic [BURST_W-1:0]        r_periods;
    logic [GAIN_W-1:0]         r_gain;
    logic                      r_stop_pend;
    logic signed [ROM_W-1:0]   r_rom_q;
    logic [GAIN_W-1:0]         r_rom_gain;
    logic                      r_rom_vld;
    logic signed [ROM_W-1:0]   r_s1;
    logic [GAIN_W-1:0]         r_s1_gain;
    logic                      r_s1_vld;

    logic [c_IDX_W-1:0]        w_last_idx;
    logic [BURST_W:0]          w_periods_next;
    logic signed [c_PROD_W-1:0] w_rom_ext;
    logic signed [c_PROD_W-1:0] w_gain_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_shift;
    logic signed [OUT_W-1:0]   w_reduced;

    function automatic logic signed [ROM_W-1:0] rom_word(input logic beacon,
                                                         input logic [c_IDX_W-1:0] idx);
        int i;
        int v;
        i = int'(idx);
        v = 1920;
        if (beacon) begin
            case (i)
                8:  v = 1580;
                9:  v = 798;
                10: v = -3;
                11: v = -804;
                12: v = -1585;
                28: v = -1577;
                29: v = -798;
                30: v = 3;
                31: v = 804;
                32: v = 1585;
                default: v = (i >= 13 && i <= 27) ? -1920 : 1920;
            endcase
        end else begin
            case (i)
                4:  v = 1100;
                5:  v = -300;
                6:  v = -1600;
                15: v = -1600;
                16: v = -300;
                17: v = 1100;
                default: v = (i >= 7 && i <= 14) ? -1920 : 1920;
            endcase
        end
        return ROM_W'(v);
    endfunction

    assign w_last_idx     = r_beacon ? c_IDX_W'(BEACON_LEN - 1) : c_IDX_W'(DIGLF_LEN - 1);
    assign w_periods_next = {1'b0, r_periods} + {{BURST_W{1'b0}}, 1'b1};

    // Gain is zero-extended so codes >= 2^(GAIN_W-1) stay positive.
    assign w_rom_ext  = {{(GAIN_W + 1){r_s1[ROM_W-1]}}, r_s1};
    assign w_gain_ext = {{(ROM_W + 1){1'b0}}, r_s1_gain};
    assign w_prod     = w_rom_ext * w_gain_ext;
    assign w_shift    = w_prod >>> GAIN_FRAC;

`ifdef MPP_PATTERN_SAT_EN
    logic [c_PROD_W-OUT_W:0] w_hi;
    assign w_hi = w_shift[c_PROD_W-1:OUT_W-1];

    always_comb begin
        w_reduced = w_shift[OUT_W-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
            w_reduced = w_shift[c_PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_shift[c_PROD_W-1:OUT_W];

    always_comb begin
        w_reduced = w_shift[OUT_W-1:0];
    end
`endif

    assign busy = (r_state != c_IDLE) | r_rom_vld | r_s1_vld | sample_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_beacon     <= 1'b0;
            r_idx        <= '0;
            r_burst      <= '0;
            r_periods    <= '0;
            r_gain       <= '0;
            r_stop_pend  <= 1'b0;
            r_rom_q      <= '0;
            r_rom_gain   <= '0;
            r_rom_vld    <= 1'b0;
            r_s1         <= '0;
            r_s1_gain    <= '0;
            r_s1_vld     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done      <= 1'b0;
            r_rom_vld <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && (mode == 2'd1 || mode == 2'd2)) begin
                        r_beacon    <= (mode == 2'd1);
                        r_burst     <= burst_len;
                        r_gain      <= gain;
                        r_idx       <= '0;
                        r_periods   <= '0;
                        r_stop_pend <= 1'b0;
                        r_state     <= c_PLAY;
                    end
                end
                c_PLAY: begin
                    // Gain travels with each word so a wrap re-latch only hits the next period.
                    r_rom_q    <= rom_word(r_beacon, r_idx);
                    r_rom_gain <= r_gain;
                    r_rom_vld  <= 1'b1;
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (r_idx == w_last_idx) begin
                        r_idx     <= '0;
                        r_periods <= r_periods + 1'b1;
                        r_gain    <= gain;
                        if (((r_burst != '0) && (w_periods_next == {1'b0, r_burst})) || r_stop_pend) begin
                            r_state <= c_FLUSH;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_FLUSH: begin
                    if (!r_rom_vld && !r_s1_vld) begin
                        r_state <= c_IDLE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            r_s1         <= r_rom_q;
            r_s1_gain    <= r_rom_gain;
            r_s1_vld     <= r_rom_vld;
            sample_valid <= r_s1_vld;
            sample_out   <= r_s1_vld ? w_reduced : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpp_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpp_pattern_player
// Purpose  : Directed self-checking bench for mpp_pattern_player (24-bit and
//            12-bit output instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpp_pattern_player;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              start;
    logic              stop;
    logic [7:0]        burst_len;
    logic [7:0]        gain;
    logic signed [23:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic signed [11:0] sample_out2;
    logic              sample_valid2;
    logic              busy2;
    logic              done2;

    int pass_cnt = 0;
    int total    = 0;

    int cap  [0:127];
    int cap2 [0:127];
    int n_cap;
    int first_cyc;
    int done_cyc;
    int gaps;
    logic busy_at_done;

    always #5 clk = ~clk;

    mpp_pattern_player dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
        .burst_len(burst_len), .gain(gain), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .done(done)
    );

    mpp_pattern_player #(.OUT_W(12)) dut12 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
        .burst_len(burst_len), .gain(gain), .sample_out(sample_out2),
        .sample_valid(sample_valid2), .busy(busy2), .done(done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse start for one edge (edge E), then follow the run until done.
    task automatic play(input logic [1:0] m, input logic [7:0] bl, input logic [7:0] g,
                        input int stop_at, input int gchg_at, input logic [7:0] gnew);
        logic prev_v;
        for (int i = 0; i < 128; i++) begin
            cap[i]  = 99999;
            cap2[i] = 99999;
        end
        n_cap = 0; first_cyc = -1; done_cyc = -1; gaps = 0; prev_v = 1'b0;
        busy_at_done = 1'b1;
        mode = m; burst_len = bl; gain = g; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            tick;
            stop = 1'b0;
            if (sample_valid) begin
                if (n_cap < 128) begin
                    cap[n_cap]  = int'(sample_out);
                    cap2[n_cap] = int'(sample_out2);
                end
                if (first_cyc < 0) first_cyc = c;
                else if (!prev_v) gaps++;
                if (n_cap == stop_at) stop = 1'b1;
                if (n_cap == gchg_at) gain = gnew;
                n_cap++;
            end
            if (done) begin
                done_cyc = c;
                busy_at_done = busy;
            end
            prev_v = sample_valid;
        end
    endtask

    initial begin
        logic bad;
        rst = 1'b1; mode = 2'd0; start = 1'b0; stop = 1'b0; burst_len = 8'd0; gain = 8'd128;
        tick; tick;
        chk("rst_valid", sample_valid, 0);
        chk("rst_out", sample_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        rst = 1'b0; mode = 2'd0; start = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (c == 1) mode = 2'd3;
            bad = bad | sample_valid | busy | done | (sample_out != 0);
        end
        start = 1'b0;
        chk("idle_mode0_3_ignored", bad, 0);

        // BEACON single burst at unity gain
        play(2'd1, 8'd1, 8'd128, -1, -1, 8'd0);
        chk("bcn_first_cyc", first_cyc, 3);
        chk("bcn_count", n_cap, 40);
        chk("bcn_gaps", gaps, 0);
        chk("bcn_s0", cap[0], 1920);
        chk("bcn_s7", cap[7], 1920);
        chk("bcn_s8", cap[8], 1580);
        chk("bcn_s10", cap[10], -3);
        chk("bcn_s13", cap[13], -1920);
        chk("bcn_s30", cap[30], 3);
        chk("bcn_s39", cap[39], 1920);
        chk("bcn_done_cyc", done_cyc, 43);
        chk("bcn_busy_at_done", busy_at_done, 0);
        tick;
        chk("bcn_done_one_cycle", done, 0);

        // DIGITAL_LF continuous, half gain, stop during period 2
        play(2'd2, 8'd0, 8'd64, 30, -1, 8'd0);
        chk("dlf_count", n_cap, 46);
        chk("dlf_s4", cap[4], 550);
        chk("dlf_s5", cap[5], -150);
        chk("dlf_s27", cap[27], 550);
        chk("dlf_s45", cap[45], 960);
        chk("dlf_gaps", gaps, 0);
        chk("dlf_done_cyc", done_cyc, 49);

        // Gain re-latched only at period wrap
        play(2'd2, 8'd2, 8'd128, -1, 10, 8'd255);
        chk("glat_count", n_cap, 46);
        chk("glat_p1_s0", cap[0], 1920);
        chk("glat_p1_s11", cap[11], -1920);
        chk("glat_p2_s0", cap[23], 3825);
        chk("glat_p2_s7", cap[30], -3825);

        // Overrange output: 24-bit fits, 12-bit wraps or saturates
        play(2'd1, 8'd1, 8'd255, -1, -1, 8'd0);
        chk("ovr24_s0", cap[0], 3825);
        chk("ovr24_s13", cap[13], -3825);
`ifdef MPP_PATTERN_SAT_EN
        chk("ovr12_s0", cap2[0], 2047);
        chk("ovr12_s13", cap2[13], -2048);
`else
        chk("ovr12_s0", cap2[0], -271);
        chk("ovr12_s13", cap2[13], 271);
`endif

        // Zero gain still yields valid samples
        play(2'd1, 8'd1, 8'd0, -1, -1, 8'd0);
        chk("g0_count", n_cap, 40);
        chk("g0_s0", cap[0], 0);

        // Reset mid-playback aborts without done
        mode = 2'd1; burst_len = 8'd0; gain = 8'd128; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick;
        chk("abort_pre_valid", sample_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_valid", sample_valid, 0);
        chk("abort_busy", busy, 0);
        bad = done;
        for (int c = 0; c < 5; c++) begin
            tick;
            bad = bad | done | busy;
        end
        chk("abort_no_done", bad, 0);
        play(2'd1, 8'd1, 8'd128, -1, -1, 8'd0);
        chk("restart_s0", cap[0], 1920);
        chk("restart_count", n_cap, 40);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpp_pattern_player.md
Name: mpp_pattern_player

Overview:
- Parametrised successor to the MPP tail-hover waveform source.
- Plays one of two stored sample patterns (BEACON, DIGITAL_LF) at one sample per clock, with programmable burst count, gain scaling, graceful stop and a done pulse.
- Sits between the mode/sequencer logic and the DAC/mixed-signal model input.
- Every pattern plays its full length; no samples are dropped at wrap.

Parameters:
- ROM_W, 24: signed width of stored samples.
- OUT_W, 24: signed width of sample_out.
- GAIN_W, 8: unsigned gain width.
- GAIN_FRAC, 7: fractional bits of gain. 128 = unity.
- BURST_W, 8: width of burst_len.
- BEACON_LEN, 40: BEACON pattern length.
- DIGLF_LEN, 23: DIGITAL_LF pattern length.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- mode, in, 2: 1 = BEACON, 2 = DIGITAL_LF, 0 or 3 = none.
- start, in, 1: begin playback. Sampled only in IDLE.
- stop, in, 1: graceful stop request.
- burst_len, in, BURST_W: number of full periods to play. 0 = continuous.
- gain, in, GAIN_W: amplitude scale.
- sample_out, out, OUT_W signed: scaled sample.
- sample_valid, out, 1: sample_out carries a pattern sample.
- busy, out, 1: high while state is not IDLE or the pipeline is non-empty.
- done, out, 1: one-cycle pulse when the last sample leaves the pipeline.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, idx=0, pipeline flushed, sample_out=0, sample_valid=0, busy=0, done=0, stop_pending=0. rst overrides all other inputs. Reset mid-playback aborts immediately with no done pulse.
- ROM contents, BEACON (idx 0..39):
  - 0..7: 1920
  - 8..12: 1580, 798, -3, -804, -1585
  - 13..27: -1920
  - 28..32: -1577, -798, 3, 804, 1585
  - 33..39: 1920
- ROM contents, DIGITAL_LF (idx 0..22):
  - 0..3: 1920
  - 4..6: 1100, -300, -1600
  - 7..14: -1920
  - 15..17: -1600, -300, 1100
  - 18..22: 1920
- States:
  - IDLE: on start=1 with mode in {1,2}, latch mode, burst_len and gain, set idx=0, go to PLAY. start with mode 0 or 3 is ignored.
  - PLAY: addresses rom[idx] each cycle.
    - idx increments and wraps to 0 after LEN-1.
    - At wrap, the period counter increments and gain is re-latched.
    - Leave to FLUSH at the end of idx LEN-1 if either (a) burst_len != 0 and periods_done == burst_len, or (b) stop_pending=1.
  - FLUSH: wait until the pipeline empties, pulse done for 1 cycle, go to IDLE.
- stop in PLAY sets stop_pending. The current period always completes. stop in IDLE or FLUSH has no effect.
- start and mode changes during PLAY or FLUSH are ignored.
- Pipeline, 2 stages:
  - Stage 1 registers the ROM word.
  - Stage 2 registers product = rom * gain (ROM_W+GAIN_W+1 bits signed, gain zero-extended), arithmetic right shift by GAIN_FRAC, then reduction to OUT_W.
  - If start is sampled at edge E, the first valid sample appears at edge E+3.
  - After that, valid samples are continuous with no gaps, including across period wrap.
- When sample_valid=0, sample_out=0.
- gain=0 produces valid zero samples.
- Burst example: burst_len=1 gives exactly LEN valid samples. burst_len=255 gives 255*LEN samples.
- done asserts the cycle after the last valid sample. busy drops in the same cycle as done.

Optional Feature:
- MPP_PATTERN_SAT_EN defined: stage-2 reduction saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: stage-2 reduction truncates to the low OUT_W bits (two's-complement wrap).

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then start=1 with mode=0 → sample_valid stays 0, sample_out=0, busy=0, done never pulses.
- Beacon single burst: mode=1, burst_len=1, gain=128, start pulse at edge E → valid from E+3 for exactly 40 cycles. Sequence: samples 0..7 = 1920, sample 10 = -3, sample 30 = 3, sample 39 = 1920. done pulses at E+43.
- DigLF continuous with stop: mode=2, burst_len=0, gain=64. Assert stop at sample 30 → output stops after sample 45 (two full periods). Sample 4 = 550, sample 27 = 550, sample 5 = -150. Exactly 46 valid samples, then done.
- Gain re-latch at wrap: mode=2, burst_len=2, gain=128 at start, change gain to 255 mid period 1 → period 1 unchanged (sample 0 = 1920). Period 2 sample 0 = 3825, sample 7 = -3825.
- Saturation, OUT_W=12, mode=1, gain=255: with MPP_PATTERN_SAT_EN → sample 0 = 2047, sample 13 = -2048. Without it → sample 0 = -271, sample 13 = 271.
- Reset mid-playback: rst=1 during PLAY period 1 → next cycle sample_valid=0, busy=0, no done. A subsequent start with mode=1 restarts at idx 0 (first sample 1920).
